// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: phase encodings, lamp patterns,
// duration limits, fallback durations and the duration validity check.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        G1R2  = 3'd1,
        Y1R2  = 3'd2,
        R1G2  = 3'd3,
        R1Y2  = 3'd4,
        FLASH = 3'd5
    } phase_t;

    // Lamp bundles are one-hot {R,Y,G}
    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;

    localparam logic [6:0] MAX_TIME = 7'd99;
    localparam logic [6:0] MIN_TIME = 7'd1;

    localparam logic [6:0] DEFAULT_GREEN  = 7'd25;
    localparam logic [6:0] DEFAULT_YELLOW = 7'd5;
    localparam logic [6:0] DEFAULT_RED    = 7'd30;

    // Sum is taken at 8 bits so two large 7-bit durations cannot wrap into a false match
    function automatic logic times_valid(input logic [6:0] g, input logic [6:0] y,
                                         input logic [6:0] r);
        logic [7:0] sum;
        sum = {1'b0, g} + {1'b0, y};
        return (sum == {1'b0, r}) && (g >= MIN_TIME) && (y >= MIN_TIME) && (r <= MAX_TIME);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-lane seconds-remaining counter: loadable, decrements on tick, flags the last second.
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] load_value,
    input  logic       tick,
    output logic [6:0] count,
    output logic       is_one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 7'd0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != 7'd0)) begin
            count <= count - 7'd1;
        end
    end

    assign is_one = (count == 7'd1);

endmodule

// File: rtl/normal_mode.sv
// Four-phase two-lane traffic-light sequencer driven by a 1 Hz tick.
// Build option FLASH_ON_INVALID_EN: invalid durations enter a flashing-yellow hold instead of using defaults.
module normal_mode
    import traffic_pkg::*;
#(
    parameter logic [6:0] DEF_GREEN  = DEFAULT_GREEN,
    parameter logic [6:0] DEF_YELLOW = DEFAULT_YELLOW,
    parameter logic [6:0] DEF_RED    = DEFAULT_RED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick,
    input  logic [6:0] greenTime,
    input  logic [6:0] yellowTime,
    input  logic [6:0] redTime,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic [6:0] timeLane1,
    output logic [6:0] timeLane2,
    output logic [2:0] state
);

    phase_t     cur_state, next_state;
    logic [6:0] g_l, y_l, r_l;
    logic [6:0] cand_g, cand_y, cand_r;
    logic       in_valid;
    logic       lit, next_lit;
    logic       start_cycle, latch;
    logic       load1, load2, dec1, dec2;
    logic [6:0] val1, val2;
    logic       t1_one, t2_one;
    logic [2:0] next_l1, next_l2;

    assign in_valid = times_valid(greenTime, yellowTime, redTime);
    assign cand_g   = in_valid ? greenTime  : DEF_GREEN;
    assign cand_y   = in_valid ? yellowTime : DEF_YELLOW;
    assign cand_r   = in_valid ? redTime    : DEF_RED;

    phase_timer u_lane1 (
        .clk        (clk),
        .reset      (reset),
        .load       (load1),
        .load_value (val1),
        .tick       (dec1),
        .count      (timeLane1),
        .is_one     (t1_one)
    );

    phase_timer u_lane2 (
        .clk        (clk),
        .reset      (reset),
        .load       (load2),
        .load_value (val2),
        .tick       (dec2),
        .count      (timeLane2),
        .is_one     (t2_one)
    );

    // The red counter always reaches 1 together with the opposing yellow, so only the
    // running green/yellow lane decides each phase change.
    always_comb begin
        next_state  = cur_state;
        next_lit    = lit;
        start_cycle = 1'b0;
        latch       = 1'b0;
        load1       = 1'b0;
        load2       = 1'b0;
        val1        = 7'd0;
        val2        = 7'd0;
        dec1        = 1'b0;
        dec2        = 1'b0;
        if (!enable) begin
            next_state = IDLE;
            load1      = 1'b1;
            load2      = 1'b1;
        end else begin
            case (cur_state)
                IDLE: start_cycle = 1'b1;
                G1R2: if (tick) begin
                    if (t1_one) begin
                        next_state = Y1R2;
                        load1      = 1'b1;
                        val1       = y_l;
                    end else begin
                        dec1 = 1'b1;
                    end
                    dec2 = 1'b1;
                end
                Y1R2: if (tick) begin
                    if (t1_one) begin
                        next_state = R1G2;
                        load1      = 1'b1;
                        val1       = r_l;
                        load2      = 1'b1;
                        val2       = g_l;
                    end else begin
                        dec1 = 1'b1;
                        dec2 = 1'b1;
                    end
                end
                R1G2: if (tick) begin
                    if (t2_one) begin
                        next_state = R1Y2;
                        load2      = 1'b1;
                        val2       = y_l;
                    end else begin
                        dec2 = 1'b1;
                    end
                    dec1 = 1'b1;
                end
                R1Y2: if (tick) begin
                    if (t2_one) begin
                        start_cycle = 1'b1;
                    end else begin
                        dec1 = 1'b1;
                        dec2 = 1'b1;
                    end
                end
`ifdef FLASH_ON_INVALID_EN
                FLASH: if (tick) begin
                    if (in_valid) start_cycle = 1'b1;
                    else          next_lit    = ~lit;
                end
`endif
                default: begin
                    next_state = IDLE;
                    load1      = 1'b1;
                    load2      = 1'b1;
                end
            endcase

            if (start_cycle) begin
`ifdef FLASH_ON_INVALID_EN
                if (in_valid) begin
                    next_state = G1R2;
                    latch      = 1'b1;
                    load1      = 1'b1;
                    val1       = cand_g;
                    load2      = 1'b1;
                    val2       = cand_r;
                end else begin
                    next_state = FLASH;
                    next_lit   = 1'b1;
                    load1      = 1'b1;
                    load2      = 1'b1;
                end
`else
                next_state = G1R2;
                latch      = 1'b1;
                load1      = 1'b1;
                val1       = cand_g;
                load2      = 1'b1;
                val2       = cand_r;
`endif
            end
        end
    end

    always_comb begin
        next_l1 = LAMP_OFF;
        next_l2 = LAMP_OFF;
        case (next_state)
            G1R2:  begin next_l1 = LAMP_G; next_l2 = LAMP_R; end
            Y1R2:  begin next_l1 = LAMP_Y; next_l2 = LAMP_R; end
            R1G2:  begin next_l1 = LAMP_R; next_l2 = LAMP_G; end
            R1Y2:  begin next_l1 = LAMP_R; next_l2 = LAMP_Y; end
            FLASH: if (next_lit) begin next_l1 = LAMP_Y; next_l2 = LAMP_Y; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            lit       <= 1'b0;
            g_l       <= 7'd0;
            y_l       <= 7'd0;
            r_l       <= 7'd0;
            light1    <= LAMP_OFF;
            light2    <= LAMP_OFF;
        end else begin
            cur_state <= next_state;
            lit       <= next_lit;
            light1    <= next_l1;
            light2    <= next_l2;
            if (latch) begin
                g_l <= cand_g;
                y_l <= cand_y;
                r_l <= cand_r;
            end
        end
    end

    assign state = cur_state;

endmodule
